// File: rtl/zero_chunk_compressor.sv
`default_nettype none
// ============================================================================
//  Module   : zero_chunk_compressor
//  Purpose  : Scans one page of cache lines, flags all-zero chunks, and
//             emits a header line plus every non-zero chunk when enough
//             chunks are zero; otherwise reports the page incompressible.
//  Revision : 1.0 - generic geometry, full non-zero transfer, bus error flag
// ============================================================================
module zero_chunk_compressor #(
    parameter int DATA_WIDTH      = 512,
    parameter int LINES_PER_PAGE  = 64,
    parameter int LINES_PER_CHUNK = 16,
    parameter int MIN_ZERO_CHUNKS = 3,
    parameter int FIFO_PTR_WIDTH  = 6,
    parameter int SIZE_WIDTH      = 16,
    localparam int NUM_CHUNKS     = LINES_PER_PAGE / LINES_PER_CHUNK
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      comp_start,
    input  logic                      rdfifo_empty,
    output logic                      rd_req,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic [1:0]                rd_rresp,
    input  logic                      rd_valid,
    output logic [FIFO_PTR_WIDTH-1:0] rdfifo_rdptr,
    output logic                      ld_rdfifo_rdptr,
    input  logic                      wrfifo_full,
    output logic                      wr_req,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [NUM_CHUNKS-1:0]     zero_chunk_vec,
    output logic [SIZE_WIDTH-1:0]     comp_size,
    output logic                      incompressible,
    output logic                      comp_done,
    output logic                      bus_error
);

    localparam int LCW            = $clog2(LINES_PER_PAGE + 1);
    localparam int CIW            = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int PCW            = $clog2(NUM_CHUNKS + 1);
    localparam int BYTES_PER_LINE = DATA_WIDTH / 8;
    localparam logic [LCW-1:0] LPC_L    = LCW'(LINES_PER_CHUNK);
    localparam logic [LCW-1:0] LPP_L    = LCW'(LINES_PER_PAGE);
    localparam logic [PCW-1:0] NCH_L    = PCW'(NUM_CHUNKS);
    localparam logic [PCW-1:0] MINZ_L   = PCW'(MIN_ZERO_CHUNKS);
    localparam logic [63:0]    SIZE_MAX = (64'd1 << SIZE_WIDTH) - 64'd1;
    localparam logic [63:0]    PAGE_BYTES = 64'(LINES_PER_PAGE) * 64'(BYTES_PER_LINE);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_DECIDE   = 3'd2,
        S_HEADER   = 3'd3,
        S_LOAD_PTR = 3'd4,
        S_XFER     = 3'd5,
        S_DONE     = 3'd6,
        S_ERROR    = 3'd7
    } state_t;

    state_t                    state_q, state_d;
    logic [LCW-1:0]            line_cnt_q, line_cnt_d;    // lines accepted this phase
    logic [LCW-1:0]            issue_cnt_q, issue_cnt_d;  // reads issued this phase
    logic                      pend_q, pend_d;            // one read in flight
    logic [LCW-1:0]            lic_q, lic_d;              // line within chunk (scan)
    logic [LCW-1:0]            zero_cnt_q, zero_cnt_d;
    logic [CIW-1:0]            chunk_idx_q, chunk_idx_d;
    logic [NUM_CHUNKS-1:0]     vec_q, vec_d;
    logic [NUM_CHUNKS-1:0]     visited_q, visited_d;
    logic [CIW-1:0]            cur_chunk_q, cur_chunk_d;
    logic                      rd_req_q, rd_req_d;
    logic [FIFO_PTR_WIDTH-1:0] rdptr_q, rdptr_d;
    logic                      ld_q, ld_d;
    logic                      wr_req_q, wr_req_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic [SIZE_WIDTH-1:0]     size_q, size_d;
    logic                      incomp_q, incomp_d;
    logic                      done_q, done_d;
    logic                      berr_q, berr_d;

    logic [PCW-1:0]            w_zero_pop;
    logic [PCW-1:0]            w_nonzero;
    logic [CIW-1:0]            w_sel_chunk;
    logic                      w_sel_found;
    logic [NUM_CHUNKS-1:0]     w_pending;
    logic                      w_more;
    logic [63:0]               w_comp_bytes;
    logic                      w_line_zero;
    logic                      w_accept;
    logic                      w_good;
    logic                      w_can_issue;

    function automatic logic [SIZE_WIDTH-1:0] sat_size(input logic [63:0] bytes);
        logic [SIZE_WIDTH-1:0] r;
        if (bytes > SIZE_MAX) begin
            r = '1;
        end else begin
            r = bytes[SIZE_WIDTH-1:0];
        end
        return r;
    endfunction

    // Chunk bookkeeping: zero-chunk popcount, lowest pending non-zero chunk, size.
    always_comb begin
        w_zero_pop  = '0;
        w_sel_chunk = '0;
        w_sel_found = 1'b0;
        w_pending   = ~vec_q & ~visited_q;
        for (int i = NUM_CHUNKS - 1; i >= 0; i--) begin
            w_zero_pop = w_zero_pop + PCW'(vec_q[i]);
            if (w_pending[i]) begin
                w_sel_chunk = CIW'(i);
                w_sel_found = 1'b1;
            end
        end
        w_more       = |(w_pending & ~(NUM_CHUNKS'(1) << cur_chunk_q));
        w_nonzero    = NCH_L - w_zero_pop;
        w_comp_bytes = (64'd1 + 64'(w_nonzero) * 64'(LINES_PER_CHUNK)) * 64'(BYTES_PER_LINE);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        line_cnt_d  = line_cnt_q;
        issue_cnt_d = issue_cnt_q;
        pend_d      = pend_q;
        lic_d       = lic_q;
        zero_cnt_d  = zero_cnt_q;
        chunk_idx_d = chunk_idx_q;
        vec_d       = vec_q;
        visited_d   = visited_q;
        cur_chunk_d = cur_chunk_q;
        rd_req_d    = 1'b0;
        rdptr_d     = rdptr_q;
        ld_d        = 1'b0;
        wr_req_d    = 1'b0;
        wr_data_d   = wr_data_q;
        size_d      = size_q;
        incomp_d    = incomp_q;

        w_line_zero = (rd_data == '0);
        w_accept    = rd_valid && pend_q;
        w_good      = w_accept && (rd_rresp == 2'b00);
        // The slot frees on the cycle a good line returns.
        w_can_issue = !pend_q || w_good;

        case (state_q)
            S_IDLE: begin
                if (comp_start && !rdfifo_empty) begin
                    state_d     = S_SCAN;
                    line_cnt_d  = '0;
                    issue_cnt_d = '0;
                    pend_d      = 1'b0;
                    lic_d       = '0;
                    zero_cnt_d  = '0;
                    chunk_idx_d = '0;
                    vec_d       = '0;
                    visited_d   = '0;
                    size_d      = '0;
                    incomp_d    = 1'b0;
                end
            end
            S_SCAN: begin
                if (w_accept) begin
                    pend_d = 1'b0;
                    if (!w_good) begin
                        state_d = S_ERROR;
                    end else begin
                        line_cnt_d = line_cnt_q + 1'b1;
                        if (lic_q == LPC_L - 1'b1) begin
                            vec_d[chunk_idx_q] = ((zero_cnt_q + LCW'(w_line_zero)) == LPC_L);
                            zero_cnt_d  = '0;
                            lic_d       = '0;
                            chunk_idx_d = chunk_idx_q + 1'b1;
                        end else begin
                            lic_d      = lic_q + 1'b1;
                            zero_cnt_d = zero_cnt_q + LCW'(w_line_zero);
                        end
                        if (line_cnt_q == LPP_L - 1'b1) begin
                            state_d = S_DECIDE;
                        end
                    end
                end
                if (state_d == S_SCAN && w_can_issue && !rdfifo_empty && issue_cnt_q < LPP_L) begin
                    rd_req_d    = 1'b1;
                    pend_d      = 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            S_DECIDE: begin
                if (w_zero_pop < MINZ_L) begin
                    state_d  = S_DONE;
                    incomp_d = 1'b1;
                    size_d   = sat_size(PAGE_BYTES);
                end else begin
                    state_d = S_HEADER;
                    size_d  = sat_size(w_comp_bytes);
                end
            end
            S_HEADER: begin
                if (!wrfifo_full) begin
                    wr_req_d  = 1'b1;
                    wr_data_d = DATA_WIDTH'(vec_q);
                    state_d   = (&vec_q) ? S_DONE : S_LOAD_PTR;
                end
            end
            S_LOAD_PTR: begin
                if (w_sel_found) begin
                    ld_d        = 1'b1;
                    rdptr_d     = FIFO_PTR_WIDTH'(32'(w_sel_chunk) * 32'(LINES_PER_CHUNK));
                    cur_chunk_d = w_sel_chunk;
                    line_cnt_d  = '0;
                    issue_cnt_d = '0;
                    pend_d      = 1'b0;
                    state_d     = S_XFER;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_XFER: begin
                if (w_accept) begin
                    pend_d = 1'b0;
                    if (!w_good) begin
                        state_d = S_ERROR;
                    end else begin
                        wr_req_d   = 1'b1;
                        wr_data_d  = rd_data;
                        line_cnt_d = line_cnt_q + 1'b1;
                        if (line_cnt_q == LPC_L - 1'b1) begin
                            visited_d[cur_chunk_q] = 1'b1;
                            state_d = w_more ? S_LOAD_PTR : S_DONE;
                        end
                    end
                end
                if (state_d == S_XFER && w_can_issue && !rdfifo_empty && !wrfifo_full
                    && issue_cnt_q < LPC_L) begin
                    rd_req_d    = 1'b1;
                    pend_d      = 1'b1;
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (!comp_start) begin
                    state_d  = S_IDLE;
                    incomp_d = 1'b0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
        berr_d = berr_q | (state_d == S_ERROR);
    end

    // State and output registers; reset aborts any operation in progress.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            line_cnt_q  <= '0;
            issue_cnt_q <= '0;
            pend_q      <= 1'b0;
            lic_q       <= '0;
            zero_cnt_q  <= '0;
            chunk_idx_q <= '0;
            vec_q       <= '0;
            visited_q   <= '0;
            cur_chunk_q <= '0;
            rd_req_q    <= 1'b0;
            rdptr_q     <= '0;
            ld_q        <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            size_q      <= '0;
            incomp_q    <= 1'b0;
            done_q      <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            line_cnt_q  <= line_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            pend_q      <= pend_d;
            lic_q       <= lic_d;
            zero_cnt_q  <= zero_cnt_d;
            chunk_idx_q <= chunk_idx_d;
            vec_q       <= vec_d;
            visited_q   <= visited_d;
            cur_chunk_q <= cur_chunk_d;
            rd_req_q    <= rd_req_d;
            rdptr_q     <= rdptr_d;
            ld_q        <= ld_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            size_q      <= size_d;
            incomp_q    <= incomp_d;
            done_q      <= done_d;
            berr_q      <= berr_d;
        end
    end

    assign rd_req          = rd_req_q;
    assign rdfifo_rdptr    = rdptr_q;
    assign ld_rdfifo_rdptr = ld_q;
    assign wr_req          = wr_req_q;
    assign wr_data         = wr_data_q;
    assign zero_chunk_vec  = vec_q;
    assign comp_size       = size_q;
    assign incompressible  = incomp_q;
    assign comp_done       = done_q;
    assign bus_error       = berr_q;

endmodule
`default_nettype wire
